// File: rtl/counter_stream_checker_if.sv
// counter_stream_checker_if: sampled counter stream in, check status and statistics out.
interface counter_stream_checker_if #(
    parameter int CNT_W  = 8,
    parameter int STAT_W = 16
);
    logic              i_en;
    logic [CNT_W-1:0]  i_cnt;
    logic              i_cout;
    logic              i_clr;
    logic              o_locked;
    logic              o_err_pulse;
    logic              o_err_sticky;
    logic [STAT_W-1:0] o_err_cnt;
    logic [STAT_W-1:0] o_wrap_cnt;
    logic [CNT_W-1:0]  o_first_exp;
    logic [CNT_W-1:0]  o_first_got;
    modport master (
        output i_en, i_cnt, i_cout, i_clr,
        input  o_locked, o_err_pulse, o_err_sticky, o_err_cnt, o_wrap_cnt, o_first_exp, o_first_got
    );
    modport slave (
        input  i_en, i_cnt, i_cout, i_clr,
        output o_locked, o_err_pulse, o_err_sticky, o_err_cnt, o_wrap_cnt, o_first_exp, o_first_got
    );
endinterface

// File: rtl/counter_stream_checker.sv
// counter_stream_checker: locks onto a wrapping counter stream and flags, counts and captures deviations.
module counter_stream_checker #(
    parameter int CNT_W   = 8,
    parameter int CNT_MAX = 255,
    parameter int STAT_W  = 16,
    parameter int LOCK_N  = 2
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    counter_stream_checker_if.slave bus
);
    localparam int RUN_W = $clog2(LOCK_N + 1);
    localparam logic [CNT_W-1:0] MAXV = CNT_W'(CNT_MAX);
    localparam logic [STAT_W-1:0] SAT = '1;
    typedef enum logic [1:0] {IDLE, ACQ, LOCK} state_t;
    state_t            r_state, w_state;
    logic [CNT_W-1:0]  r_exp, w_exp, w_nxt;
    logic [CNT_W-1:0]  r_first_exp, w_first_exp, r_first_got, w_first_got;
    logic [RUN_W-1:0]  r_run, w_run, w_run_inc;
    logic              r_pulse, w_pulse, r_sticky, w_sticky;
    logic [STAT_W-1:0] r_err_cnt, w_err_cnt, r_wrap_cnt, w_wrap_cnt;
    logic              w_at_max, w_match;
    assign w_at_max  = bus.i_cnt == MAXV;
    assign w_nxt     = w_at_max ? '0 : bus.i_cnt + CNT_W'(1);
    assign w_match   = (bus.i_cnt == r_exp) && (bus.i_cout == w_at_max);
    assign w_run_inc = r_run + RUN_W'(1);
    // Clear is folded into the base values so a same-cycle error/wrap lands on top of it.
    always_comb begin
        w_state     = r_state;
        w_exp       = r_exp;
        w_run       = r_run;
        w_pulse     = 1'b0;
        w_sticky    = bus.i_clr ? 1'b0 : r_sticky;
        w_err_cnt   = bus.i_clr ? '0 : r_err_cnt;
        w_wrap_cnt  = bus.i_clr ? '0 : r_wrap_cnt;
        w_first_exp = bus.i_clr ? '0 : r_first_exp;
        w_first_got = bus.i_clr ? '0 : r_first_got;
        if (bus.i_en) begin
            w_exp = w_nxt;
            unique case (r_state)
                IDLE: begin
                    w_run   = RUN_W'(1);
                    w_state = (LOCK_N == 1) ? LOCK : ACQ;
                end
                ACQ: begin
                    w_run   = w_match ? w_run_inc : RUN_W'(1);
                    w_state = (w_match && w_run_inc == RUN_W'(LOCK_N)) ? LOCK : ACQ;
                end
                LOCK: begin
                    if (w_match) begin
                        w_wrap_cnt = (w_at_max && w_wrap_cnt != SAT) ? w_wrap_cnt + STAT_W'(1) : w_wrap_cnt;
                    end else begin
                        w_pulse     = 1'b1;
                        w_err_cnt   = (w_err_cnt != SAT) ? w_err_cnt + STAT_W'(1) : w_err_cnt;
                        w_first_exp = w_sticky ? w_first_exp : r_exp;
                        w_first_got = w_sticky ? w_first_got : bus.i_cnt;
                        w_sticky    = 1'b1;
                        w_run       = RUN_W'(1);
                        w_state     = ACQ;
                    end
                end
                default: w_state = IDLE;
            endcase
        end
    end
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= IDLE;
            r_exp       <= '0;
            r_run       <= '0;
            r_pulse     <= 1'b0;
            r_sticky    <= 1'b0;
            r_err_cnt   <= '0;
            r_wrap_cnt  <= '0;
            r_first_exp <= '0;
            r_first_got <= '0;
        end else begin
            r_state     <= w_state;
            r_exp       <= w_exp;
            r_run       <= w_run;
            r_pulse     <= w_pulse;
            r_sticky    <= w_sticky;
            r_err_cnt   <= w_err_cnt;
            r_wrap_cnt  <= w_wrap_cnt;
            r_first_exp <= w_first_exp;
            r_first_got <= w_first_got;
        end
    end
    assign bus.o_locked     = r_state == LOCK;
    assign bus.o_err_pulse  = r_pulse;
    assign bus.o_err_sticky = r_sticky;
    assign bus.o_err_cnt    = r_err_cnt;
    assign bus.o_wrap_cnt   = r_wrap_cnt;
    assign bus.o_first_exp  = r_first_exp;
    assign bus.o_first_got  = r_first_got;
endmodule
